par8_rx_buffer: RTL and testbench

- Receive-side front end of the RPi 8-bit parallel bus. Feeds cmd_parser's rxd_data/rxd_data_ready path.
- Synchronises the asynchronous bus_clk, bus_rnw and bus_data into the clk domain.
- Captures one byte per bus_clk rising edge while the master writes, and buffers the bytes in a FIFO.
- Presents the bytes on a valid/ready stream and raises a busy flag so the RPi can throttle.

---
 rtl/par8_pkg.sv | 12 +
 rtl/par8_rx_buffer_if.sv | 9 +
 rtl/par8_sync_fifo.sv | 48 ++++
 rtl/par8_rx_buffer.sv | 61 ++++++
 tb/tb_par8_rx_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/par8_pkg.sv
// par8_pkg: shared constants and helpers for the RPi 8-bit parallel receive path
package par8_pkg;
  localparam int BUS_W     = 8;
  localparam int DEPTH_DEF = 16;
  localparam int AFULL_DEF = 12;
  localparam int SYNC_DEF  = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/par8_rx_buffer_if.sv
// par8_rx_buffer_if: valid/ready byte stream; master = buffer, slave = consumer (cmd_parser)
interface par8_rx_buffer_if;
  import par8_pkg::*;
  logic [BUS_W-1:0] rxd_data;
  logic             rxd_valid;
  logic             rxd_ready;
  modport master(output rxd_data, rxd_valid, input rxd_ready);
  modport slave(input rxd_data, rxd_valid, output rxd_ready);
endinterface

// File: rtl/par8_sync_fifo.sv
// par8_sync_fifo: single-clock FWFT FIFO with registered head; ports push/wdata in,
// pop/rdata/rvalid out, fill_level/fill_next occupancy, full flag; async active-low reset
module par8_sync_fifo
  import par8_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int W     = BUS_W,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          rvalid,
  output logic [AW:0]   fill_level,
  output logic [AW:0]   fill_next,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   mem_cnt;
  logic          do_pop, do_push, load;
  // fill_level counts the head register too; mem_cnt is what still sits in the RAM
  assign do_pop    = pop & rvalid;
  assign full      = fill_level == (AW+1)'(DEPTH);
  assign do_push   = push & (~full | do_pop);
  assign mem_cnt   = fill_level - (AW+1)'(rvalid);
  assign load      = (mem_cnt != '0) & (~rvalid | do_pop);
  assign fill_next = fill_level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_level <= '0;
      rvalid     <= 1'b0;
      rdata      <= '0;
    end else begin
      wptr       <= wptr + AW'(do_push);
      rptr       <= rptr + AW'(load);
      fill_level <= fill_next;
      rvalid     <= load | (rvalid & ~do_pop);
      if (load) rdata <= mem[rptr];
    end
endmodule

// File: rtl/par8_rx_buffer.sv
// par8_rx_buffer: synchronises the RPi write strobe/data, buffers bytes in a FIFO
// ports: clk, reset (async active-low), bus_clk/bus_data/bus_rnw (async RPi bus),
// rxd (valid/ready stream master), bus_busy, fill_level, overflow (sticky), clear_ovf
module par8_rx_buffer
  import par8_pkg::*;
#(
  parameter  int DEPTH       = DEPTH_DEF,
  parameter  int AFULL_LEVEL = AFULL_DEF,
  parameter  int SYNC_STAGES = SYNC_DEF,
  localparam int AW          = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_clk,
  input  logic [BUS_W-1:0] bus_data,
  input  logic             bus_rnw,
  par8_rx_buffer_if.master rxd,
  output logic             bus_busy,
  output logic [AW:0]      fill_level,
  output logic             overflow,
  input  logic             clear_ovf
);
  // bus_clk and bus_rnw idle high out of reset so a held-high strobe is not an edge
  localparam logic [BUS_W+1:0] SYNC_RST = {2'b11, BUS_W'(0)};
  logic [BUS_W+1:0] raw, sync;
  logic [AW:0]      fill_next;
  logic             clk_prev, wr_stb, full, drop;
  assign raw = {bus_rnw, bus_clk, bus_data};
  for (genvar i = 0; i < BUS_W + 2; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge clk or negedge reset)
      if (!reset) sr <= {SYNC_STAGES{SYNC_RST[i]}};
      else sr <= {sr[SYNC_STAGES-2:0], raw[i]};
    assign sync[i] = sr[SYNC_STAGES-1];
  end
  assign wr_stb = sync[BUS_W] & ~clk_prev & ~sync[BUS_W+1];
  assign drop   = wr_stb & full & ~(rxd.rxd_valid & rxd.rxd_ready);
  par8_sync_fifo #(.DEPTH(DEPTH), .W(BUS_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_stb),
    .wdata     (sync[BUS_W-1:0]),
    .pop       (rxd.rxd_ready),
    .rdata     (rxd.rxd_data),
    .rvalid    (rxd.rxd_valid),
    .fill_level(fill_level),
    .fill_next (fill_next),
    .full      (full)
  );
  // a new drop outranks a coincident clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      clk_prev <= 1'b1;
      bus_busy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      clk_prev <= sync[BUS_W];
      bus_busy <= fill_next >= (AW+1)'(AFULL_LEVEL);
      overflow <= drop | (overflow & ~clear_ovf);
    end
endmodule

// File: tb/tb_par8_rx_buffer.sv
// tb_par8_rx_buffer: randomized and directed checks of par8_rx_buffer against a queue model
module tb_par8_rx_buffer;
  import par8_pkg::*;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  logic       clk = 0, reset = 1, bus_clk = 0, bus_rnw = 1, clear_ovf = 0;
  logic [7:0] bus_data = 0;
  logic       bus_busy, overflow;
  logic [4:0] fill_level;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 0;
  bit         done = 0;
  int         n_tests = 0, n_fail = 0, n_out = 0, n0 = 0;
  par8_rx_buffer_if rxd();
  par8_rx_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus_clk(bus_clk), .bus_data(bus_data), .bus_rnw(bus_rnw),
    .rxd(rxd), .bus_busy(bus_busy), .fill_level(fill_level), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (reset && rxd.rxd_valid && rxd.rxd_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("extra_byte", {24'h0, rxd.rxd_data}, 32'hffff_ffff);
      else check("rx_data", {24'h0, rxd.rxd_data}, {24'h0, exp_q.pop_front()});
    end
  // one RPi bus cycle: data/rnw set up 20 ns ahead, strobe 40 ns high, 40 ns hold after fall
  task automatic bus_wr(input logic [7:0] d, input logic rnw);
    @(posedge clk);
    #2 bus_data = d;
    bus_rnw = rnw;
    #20 bus_clk = 1;
    if (!rnw) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1;
    end
    #40 bus_clk = 0;
    #40;
  endtask
  initial begin
    rxd.rxd_ready = 1;
    #2 reset = 0;
    #1;
    check("rst_valid", rxd.rxd_valid, 0);
    check("rst_data", rxd.rxd_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_ovf", overflow, 0);
    #30 reset = 1;
    repeat (3) @(posedge clk);
    // single write latency and one-cycle pulse
    @(posedge clk);
    #2 bus_data = 8'hA5;
    bus_rnw = 0;
    #20 bus_clk = 1;
    exp_q.push_back(8'hA5);
    #33 check("lat_early", rxd.rxd_valid, 0);
    #7 bus_clk = 0;
    #3 check("lat_valid", rxd.rxd_valid, 1);
    check("lat_data", rxd.rxd_data, 8'hA5);
    #10 check("lat_pulse", rxd.rxd_valid, 0);
    #20 check("lat_fill", fill_level, 0);
    // read-mode strobes are ignored
    n0 = n_out;
    repeat (10) bus_wr(8'h11, 1);
    check("rd_nout", n_out - n0, 0);
    check("rd_fill", fill_level, 0);
    // back-pressure and busy threshold
    @(posedge clk);
    #1 rxd.rxd_ready = 0;
    for (int i = 0; i < 11; i++) bus_wr(8'(i), 0);
    check("bp_fill11", fill_level, 11);
    check("bp_busy11", bus_busy, 0);
    bus_wr(8'h0B, 0);
    check("bp_fill12", fill_level, 12);
    check("bp_busy12", bus_busy, 1);
    for (int i = 12; i < 16; i++) bus_wr(8'(i), 0);
    check("bp_fill16", fill_level, 16);
    check("bp_head", rxd.rxd_data, 8'h00);
    check("bp_hold", rxd.rxd_valid, 1);
    n0 = n_out;
    @(posedge clk);
    #1 rxd.rxd_ready = 1;
    repeat (20) begin
      @(posedge clk);
      #1 check("drain_fill", fill_level, exp_q.size());
      check("drain_busy", bus_busy, exp_q.size() >= AFULL);
    end
    check("drain_nout", n_out - n0, 16);
    // overflow: drop when full, sticky until cleared
    @(posedge clk);
    #1 rxd.rxd_ready = 0;
    for (int i = 0; i < 16; i++) bus_wr(8'($urandom_range(0, 200)), 0);
    bus_wr(8'hEE, 0);
    check("ovf_set", overflow, exp_ovf);
    check("ovf_fill", fill_level, 16);
    @(posedge clk);
    #1 clear_ovf = 1;
    @(posedge clk);
    #1 clear_ovf = 0;
    exp_ovf = 0;
    check("ovf_clr", overflow, exp_ovf);
    // full with a pop exactly in the strobe cycle
    @(posedge clk);
    #2 bus_data = 8'h77;
    bus_rnw = 0;
    #20 bus_clk = 1;
    exp_q.push_back(8'h77);
    #19 rxd.rxd_ready = 1;
    #10 rxd.rxd_ready = 0;
    #11 bus_clk = 0;
    #40;
    check("fpop_ovf", overflow, 0);
    check("fpop_fill", fill_level, 16);
    @(posedge clk);
    #1 rxd.rxd_ready = 1;
    repeat (25) @(posedge clk);
    #1 check("fpop_drained", exp_q.size(), 0);
    check("fpop_fill0", fill_level, 0);
    // randomized traffic with random consumer stalls
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          bus_wr(8'($urandom), $urandom_range(0, 3) == 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rxd.rxd_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rxd.rxd_ready = 1;
    repeat (40) @(posedge clk);
    #1 check("rnd_drained", exp_q.size(), 0);
    check("rnd_fill", fill_level, 0);
    check("rnd_ovf", overflow, exp_ovf);
    // bus_clk held high across reset release gives no capture
    n0 = n_out;
    @(posedge clk);
    #2 bus_rnw = 0;
    bus_data = 8'h5A;
    bus_clk = 1;
    #10 reset = 0;
    #13 reset = 1;
    repeat (10) @(posedge clk);
    #1 bus_clk = 0;
    repeat (10) @(posedge clk);
    #1 check("hold_fill", fill_level, 0);
    check("hold_nout", n_out - n0, 0);
    // reset mid-operation flushes the FIFO
    rxd.rxd_ready = 0;
    for (int i = 0; i < 5; i++) bus_wr(8'(8'hC0 + i), 0);
    check("mid_fill5", fill_level, 5);
    #3 reset = 0;
    #1 check("mid_fill", fill_level, 0);
    check("mid_valid", rxd.rxd_valid, 0);
    check("mid_ovf", overflow, 0);
    exp_q.delete();
    exp_ovf = 0;
    #20 reset = 1;
    rxd.rxd_ready = 1;
    n0 = n_out;
    for (int i = 0; i < 40; i++) bus_wr(8'(i), 0);
    repeat (20) @(posedge clk);
    #1 check("wrap_nout", n_out - n0, 40);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_fill", fill_level, 0);
    check("wrap_ovf", overflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
